// File: rtl/servo_sequencer.sv
// servo_sequencer: multi-channel RC servo pulse sequencer.
// Channels are pulsed one after another inside a fixed frame. Each pulse is
// followed by a fixed gap. Position writes land in shadow registers and are
// copied to the active set at every frame start.
// Optional build macro SERVO_SEQ_CH_MASK_EN adds a per-channel enable input
// ch_en. It is sampled at frame start, and disabled channels are skipped.
module servo_sequencer #(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned FRAME_US  = 20_000,
   parameter int unsigned MIN_US    = 500,
   parameter int unsigned MAX_US    = 2500,
   parameter int unsigned CENTER_US = 1500,
   parameter int unsigned GAP_US    = 50
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [2:0]        wr_ch,
   input  logic [11:0]       wr_pos,
`ifdef SERVO_SEQ_CH_MASK_EN
   input  logic [NUM_CH-1:0] ch_en,
`endif
   output logic [NUM_CH-1:0] servo_out,
   output logic              frame_start,
   output logic              busy
);

   localparam int unsigned TICK_DIV = CLK_FREQ / 1_000_000;
   localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned FRAME_W  = $clog2(FRAME_US);
   localparam int unsigned POS_W    = 12;
   localparam int unsigned CH_IDX_W = $clog2(NUM_CH);

   // Elaboration-time parameter sanity checks
   if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
      $error("servo_sequencer: NUM_CH must be 2..8");
   end
   if (NUM_CH * (MAX_US + GAP_US) >= FRAME_US) begin : g_bad_frame
      $error("servo_sequencer: frame too short for NUM_CH*(MAX_US+GAP_US)");
   end
   if (TICK_DIV < 1) begin : g_bad_clk
      $error("servo_sequencer: CLK_FREQ must be at least 1 MHz");
   end

   typedef enum logic [1:0] {IDLE, PULSE, GAP, WAIT} state_t;

   state_t               state_q, state_d;
   logic [CH_IDX_W-1:0]  ch_q, ch_d;
   logic [POS_W-1:0]     cnt_q, cnt_d;
   logic [NUM_CH-1:0]    servo_d;
   logic                 frame_start_d, busy_d, wr_ready_d;
   logic [TICK_W-1:0]    tick_cnt;
   logic [FRAME_W-1:0]   frame_cnt;
   logic                 tick_c, copy_c, wr_ok_c;
   logic [POS_W-1:0]     pos_c;
   logic [POS_W-1:0]     shadow_q [NUM_CH];
   logic [POS_W-1:0]     active_q [NUM_CH];
   logic [NUM_CH-1:0]    en_now_c, en_q;
   logic [CH_IDX_W-1:0]  first_ch_c, next_ch_c;
   logic                 first_found_c, next_found_c;

`ifdef SERVO_SEQ_CH_MASK_EN
   assign en_now_c = ch_en;
`else
   assign en_now_c = '1;
`endif

   assign tick_c  = (tick_cnt == TICK_W'(TICK_DIV - 1));
   assign wr_ok_c = wr_valid && wr_ready && (32'(wr_ch) < NUM_CH);
   assign pos_c   = (wr_pos < POS_W'(MIN_US)) ? POS_W'(MIN_US) :
                    (wr_pos > POS_W'(MAX_US)) ? POS_W'(MAX_US) : wr_pos;

   // 1 us tick prescaler
   always_ff @(posedge clk) begin
      if (!rst)        tick_cnt <= '0;
      else if (tick_c) tick_cnt <= '0;
      else             tick_cnt <= tick_cnt + TICK_W'(1);
   end

   // Frame position counter in microseconds
   always_ff @(posedge clk) begin
      if (!rst) begin
         frame_cnt <= '0;
      end else if (tick_c) begin
         if (frame_cnt == FRAME_W'(FRAME_US - 1)) frame_cnt <= '0;
         else                                     frame_cnt <= frame_cnt + FRAME_W'(1);
      end
   end

   // Shadow positions: clamped host writes, last write wins
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= POS_W'(CENTER_US);
      end else if (wr_ok_c) begin
         shadow_q[CH_IDX_W'(wr_ch)] <= pos_c;
      end
   end

   // Active positions and channel enables, latched once per frame
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) active_q[i] <= POS_W'(CENTER_US);
         en_q <= '1;
      end else if (copy_c) begin
         for (int i = 0; i < NUM_CH; i++) active_q[i] <= shadow_q[i];
         en_q <= en_now_c;
      end
   end

   // Lowest enabled channel for frame start, next enabled channel after ch_q
   always_comb begin
      first_found_c = 1'b0;
      first_ch_c    = '0;
      next_found_c  = 1'b0;
      next_ch_c     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (en_now_c[i] && !first_found_c) begin
            first_found_c = 1'b1;
            first_ch_c    = CH_IDX_W'(i);
         end
         if (en_q[i] && (CH_IDX_W'(i) > ch_q) && !next_found_c) begin
            next_found_c = 1'b1;
            next_ch_c    = CH_IDX_W'(i);
         end
      end
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         ch_q        <= '0;
         cnt_q       <= '0;
         servo_out   <= '0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
         wr_ready    <= 1'b1;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         cnt_q       <= cnt_d;
         servo_out   <= servo_d;
         frame_start <= frame_start_d;
         busy        <= busy_d;
         wr_ready    <= wr_ready_d;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d       = state_q;
      ch_d          = ch_q;
      cnt_d         = cnt_q;
      servo_d       = servo_out;
      frame_start_d = 1'b0;
      busy_d        = busy;
      wr_ready_d    = 1'b1;
      copy_c        = 1'b0;
      case (state_q)
         IDLE, WAIT: begin
            if (tick_c && frame_cnt == '0) begin
               copy_c        = 1'b1;
               frame_start_d = 1'b1;
               wr_ready_d    = 1'b0;
               cnt_d         = '0;
               servo_d       = '0;
               if (first_found_c) begin
                  state_d             = PULSE;
                  ch_d                = first_ch_c;
                  servo_d[first_ch_c] = 1'b1;
                  busy_d              = 1'b1;
               end else begin
                  state_d = WAIT;
                  busy_d  = 1'b0;
               end
            end
         end
         PULSE: begin
            if (tick_c) begin
               if (cnt_q == active_q[ch_q] - POS_W'(1)) begin
                  state_d = GAP;
                  cnt_d   = '0;
                  servo_d = '0;
               end else begin
                  cnt_d = cnt_q + POS_W'(1);
               end
            end
         end
         GAP: begin
            if (tick_c) begin
               if (cnt_q == POS_W'(GAP_US - 1)) begin
                  cnt_d = '0;
                  if (next_found_c) begin
                     state_d            = PULSE;
                     ch_d               = next_ch_c;
                     servo_d[next_ch_c] = 1'b1;
                  end else begin
                     state_d = WAIT;
                     busy_d  = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q + POS_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
